// File: rtl/multiplicador_sequencial_if.sv
// Operand/result bundle for the sequential multiplier.
// The master drives operands and start; the slave returns product and status.
interface multiplicador_sequencial_if #(
    parameter int N = 8
);
    logic             start;
    logic [N-1:0]     A;
    logic [N-1:0]     B;
    logic [2*N-1:0]   P;
    logic             busy;
    logic             done;

    modport master (
        output start, A, B,
        input  P, busy, done
    );

    modport slave (
        input  start, A, B,
        output P, busy, done
    );
endinterface

// File: rtl/multiplicador_sequencial.sv
// Unsigned shift-and-add multiplier, one partial product per clock.
// Product register holds the last result until a new one is written.
module multiplicador_sequencial #(
    parameter int N = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    multiplicador_sequencial_if.slave bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     m_q, m_d;
    logic [N-1:0]     q_q, q_d;
    logic [N:0]       acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*N-1:0]   p_q, p_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [N:0]       sum;
    logic [2*N:0]     sh;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        q_d     = q_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum     = '0;
        sh      = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    m_d     = bus.A;
                    q_d     = bus.B;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // carry of the add lands in the top bit, then shifts into ACC[N-1]
                sum   = {1'b0, acc_q[N-1:0]} + (q_q[0] ? {1'b0, m_q} : '0);
                sh    = {sum, q_q} >> 1;
                acc_d = sh[2*N:N];
                q_d   = sh[N-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                p_d     = {acc_q[N-1:0], q_q};
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.P    = p_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_multiplicador_sequencial.sv
// Directed and random bench for the sequential multiplier.
// A cycle-level transaction model is checked against the DUT on every negedge.
module tb_multiplicador_sequencial;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    multiplicador_sequencial_if #(.N(N)) bus ();

    multiplicador_sequencial #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Transaction-level reference: product A*B appears N+1 edges after accept.
    int               cyc = 0;
    int               due = 0;
    bit               m_busy = 1'b0;
    bit               m_done = 1'b0;
    logic [2*N-1:0]   m_p = '0;
    logic [2*N-1:0]   m_prod = '0;
    bit               chk_en = 1'b0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_p    = '0;
            chk_en = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_busy && cyc == due) begin
                m_p    = m_prod;
                m_done = 1'b1;
                m_busy = 1'b0;
            end else if (!m_busy && bus.start) begin
                m_busy = 1'b1;
                m_prod = (2*N)'(bus.A) * (2*N)'(bus.B);
                due    = cyc + N + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_P", 32'(bus.P), 32'(m_p));
            chk("model_busy", 32'(bus.busy), 32'(m_busy));
            chk("model_done", 32'(bus.done), 32'(m_done));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // Waits for done after an accepting edge; start is dropped once done shows.
    task automatic wait_done(input string name, input logic [2*N-1:0] exp);
        int n;
        n = 0;
        while (n < 20) begin
            step();
            n++;
            if (bus.done) break;
        end
        bus.start = 1'b0;
        chk({name, "_latency"}, 32'(n), 32'(N + 1));
        chk({name, "_P"}, 32'(bus.P), 32'(exp));
    endtask

    task automatic expect_no_done(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (bus.done) seen++;
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        rst       = 1'b1;
        step();
        step();
        chk("rst_P", 32'(bus.P), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        rst = 1'b0;
        step();

        launch(8'd13, 8'd11);
        chk("busy_after_accept", 32'(bus.busy), 32'h1);
        wait_done("m13x11", 16'h008F);
        step();
        chk("done_one_cycle", 32'(bus.done), 32'h0);
        chk("P_held", 32'(bus.P), 32'h008F);

        launch(8'hFF, 8'hFF);
        wait_done("mFFxFF", 16'hFE01);
        step();
        launch(8'h00, 8'hA5);
        wait_done("m00xA5", 16'h0000);
        step();
        launch(8'h80, 8'h02);
        wait_done("m80x02", 16'h0100);
        step();

        // start kept high during RUN with different operands
        bus.A     = 8'd7;
        bus.B     = 8'd6;
        bus.start = 1'b1;
        step();
        bus.A = 8'd3;
        bus.B = 8'd3;
        wait_done("m7x6_held", 16'h002A);
        expect_no_done("no_second_op", 12);

        // reset in the 4th RUN cycle
        launch(8'd200, 8'd100);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_P", 32'(bus.P), 32'h0);
        chk("midrst_busy", 32'(bus.busy), 32'h0);
        chk("midrst_done", 32'(bus.done), 32'h0);
        expect_no_done("midrst_no_done", 12);
        launch(8'd2, 8'd3);
        wait_done("m2x3", 16'h0006);

        // back-to-back: accepted in the done cycle
        launch(8'd5, 8'd9);
        chk("b2b_prev_held", 32'(bus.P), 32'h0006);
        wait_done("m5x9", 16'h002D);
        step();

        for (int i = 0; i < 1000; i++) begin
            logic [N-1:0] a;
            logic [N-1:0] b;
            a = N'($urandom_range(0, 255));
            b = N'($urandom_range(0, 255));
            launch(a, b);
            wait_done("rand", (2*N)'(a) * (2*N)'(b));
            if ($urandom_range(0, 1) == 1) step();
        end

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
